// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: 3-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Build option: define CLA_PIPE_OVF_EN to register a two's-complement overflow flag; otherwise ovf is tied to 0.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NG = WIDTH / 4;

  logic             en;

  // Stage 1: bit and group propagate/generate
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_gp_q, s1_gp_d;
  logic [NG-1:0]    s1_gg_q, s1_gg_d;
  logic             s1_c0_q, s1_c0_d;

  // Stage 2: group carry-ins
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;
  logic [WIDTH-1:0] s2_g_q, s2_g_d;
  logic [NG-1:0]    s2_gc_q, s2_gc_d;
  logic             s2_cout_q, s2_cout_d;

  // Stage 3: result registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;
  logic             s2_term, s2_acc;
  logic             s3_term, s3_acc;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    b_eff = sub ? ~b : b;
    bit_p = a ^ b_eff;
    bit_g = a & b_eff;
    for (int unsigned i = 0; i < NG; i++) begin
      grp_p[i] = &bit_p[4*i +: 4];
      grp_g[i] = bit_g[4*i+3]
               | (bit_p[4*i+3] & bit_g[4*i+2])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
    end

    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_gp_d    = s1_gp_q;
    s1_gg_d    = s1_gg_q;
    s1_c0_d    = s1_c0_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_p_d     = bit_p;
      s1_g_d     = bit_g;
      s1_gp_d    = grp_p;
      s1_gg_d    = grp_g;
      s1_c0_d    = sub ? 1'b1 : cin;
    end
  end

  // Each group carry is a flat sum of products over group P/G and c0 (no inter-group ripple).
  // grp_c[NG] is the carry out of the top group, i.e. cout.
  always_comb begin
    grp_c   = '0;
    s2_term = 1'b0;
    s2_acc  = 1'b0;
    for (int unsigned k = 0; k <= NG; k++) begin
      s2_acc = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        s2_term = s1_gg_q[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          s2_term = s2_term & s1_gp_q[m];
        end
        s2_acc = s2_acc | s2_term;
      end
      s2_term = s1_c0_q;
      for (int unsigned m = 0; m < k; m++) begin
        s2_term = s2_term & s1_gp_q[m];
      end
      grp_c[k] = s2_acc | s2_term;
    end

    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_g_d     = s2_g_q;
    s2_gc_d    = s2_gc_q;
    s2_cout_d  = s2_cout_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_p_d     = s1_p_q;
      s2_g_d     = s1_g_q;
      s2_gc_d    = grp_c[NG-1:0];
      s2_cout_d  = grp_c[NG];
    end
  end

  // Bit carries inside each group, seeded from that group's carry-in.
  always_comb begin
    bit_c   = '0;
    s3_term = 1'b0;
    s3_acc  = 1'b0;
    for (int unsigned i = 0; i < NG; i++) begin
      for (int unsigned n = 0; n < 4; n++) begin
        s3_acc = 1'b0;
        for (int unsigned j = 0; j < n; j++) begin
          s3_term = s2_g_q[4*i+j];
          for (int unsigned m = j + 1; m < n; m++) begin
            s3_term = s3_term & s2_p_q[4*i+m];
          end
          s3_acc = s3_acc | s3_term;
        end
        s3_term = s2_gc_q[i];
        for (int unsigned m = 0; m < n; m++) begin
          s3_term = s3_term & s2_p_q[4*i+m];
        end
        bit_c[4*i+n] = s3_acc | s3_term;
      end
    end

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      sum_d       = s2_p_q ^ bit_c;
      cout_d      = s2_cout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_p_q    <= s1_p_d;
    s1_g_q    <= s1_g_d;
    s1_gp_q   <= s1_gp_d;
    s1_gg_q   <= s1_gg_d;
    s1_c0_q   <= s1_c0_d;
    s2_p_q    <= s2_p_d;
    s2_g_q    <= s2_g_d;
    s2_gc_q   <= s2_gc_d;
    s2_cout_q <= s2_cout_d;
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (en) begin
      ovf_d = bit_c[WIDTH-1] ^ s2_cout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 Port: in_ready  output  1  block accepts the operand set this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry-in; used in add mode only.
REQ-010 Port: sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-011 Port: sum  output  WIDTH  result.
REQ-012 Port: cout  output  1  carry-out of the MSB.
REQ-013 Port: ovf  output  1  two's-complement overflow flag (see Configuration).
REQ-014 Port: out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-015 Port: out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-016 Add mode (sub=0) SHALL produce {cout,sum} = a + b + cin.
REQ-017 Subtract mode (sub=1) SHALL produce {cout,sum} = a + ~b + 1 and ignore cin; cout=1 means no borrow.
REQ-018 Carries SHALL be computed by lookahead: per-bit p=a^b', g=a&b'; 4-bit groups produce group P/G; a second lookahead level across the WIDTH/4 groups produces group carry-ins; no ripple chain across group boundaries.
REQ-019 Pipeline SHALL have 3 register stages: S1 latches operands with b' and c0 formed and computes bit p/g and group P/G; S2 computes all group carry-ins; S3 computes sum, cout and ovf.
REQ-020 Latency SHALL be exactly 3 cycles from the accepting edge to out_valid=1 when out_ready stays high.
REQ-021 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-022 Advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en; all stages move together only when en=1.
REQ-023 An operation is accepted on an edge where in_valid & in_ready; in_valid=0 with en=1 inserts a bubble (stage valid=0).
REQ-024 When en=0, every stage register, sum, cout, ovf and out_valid SHALL hold their values; no result is lost or duplicated.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 sum/cout/ovf SHALL be ignored by the consumer when out_valid=0; they are not required to be zero.

Reset
REQ-027 While rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and sum, cout and ovf SHALL clear to 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset, since out_valid=0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear at the output afterwards.
REQ-030 rst SHALL take priority over in_valid on the same edge; an operand presented on that edge is not accepted.

Configuration
REQ-031 Macro CLA_PIPE_OVF_EN SHALL control overflow detection.
REQ-032 Defined: ovf SHALL equal the carry into the MSB XOR cout, registered in S3 alongside sum.
REQ-033 Undefined: the ovf port SHALL remain present and be driven constant 0, with no overflow logic instantiated.

Verification (WIDTH=16, out_ready=1 unless stated)
REQ-034 a=0x00FF, b=0x0001, cin=0, sub=0 -> 3 cycles later sum=0x0100, cout=0, ovf=0.
REQ-035 a=0xFFFF, b=0x0000, cin=1, sub=0 (carry crosses all 4 groups) -> sum=0x0000, cout=1, ovf=0.
REQ-036 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; cin ignored.
REQ-037 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1 with CLA_PIPE_OVF_EN defined, ovf=0 without.
REQ-038 Stream 6 back-to-back ops, drop out_ready for 2 cycles after the first result -> in_ready=0 during the stall, outputs held, all 6 results in order with none missing or duplicated.
REQ-039 Accept 2 ops, assert rst for 1 cycle before either emerges -> out_valid=0 and sum=0 after the reset edge, and neither op is ever output.
